// File: rtl/pipe_stage_hs.sv
// pipe_stage_hs: reusable pipeline stage register with valid/ready handshake,
// synchronous flush and an optional 2-entry skid buffer.
//
// Parameters:
//   WIDTH      payload width in bits
//   NOP_VALUE  payload presented whenever the stage holds no valid beat
//   SKID       1 = registered in_ready with 2-entry skid buffer
//              0 = single register, combinational in_ready
//
// Ports:
//   clk        clock, all state updates on rising edge
//   rst        synchronous active-high reset
//   flush      synchronous; discards all held beats
//   in_valid   upstream beat valid
//   in_ready   stage can accept a beat this cycle
//   in_data    upstream payload
//   out_valid  stage presents a valid beat
//   out_ready  downstream accepts
//   out_data   payload, NOP_VALUE whenever out_valid = 0
//   occupancy  beats held: 0, 1 or 2
module pipe_stage_hs #(
    parameter int unsigned      WIDTH     = 32,
    parameter logic [WIDTH-1:0] NOP_VALUE = '0,
    parameter bit               SKID      = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    // Encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        EMPTY     = 2'd0,
        FULL      = 2'd1,
        SKID_FULL = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             in_fire;
    logic             out_fire;

    assign out_valid = (state_q != EMPTY);
    // main_q is reloaded with NOP_VALUE whenever the stage empties, so it
    // can drive out_data directly without a bubble mux.
    assign out_data  = main_q;
    assign occupancy = state_q;

    generate
        if (SKID) begin : g_skid_ready
            // Depends only on registered state: no path from out_ready.
            assign in_ready = (state_q != SKID_FULL);
        end else begin : g_comb_ready
            assign in_ready = ~out_valid | out_ready;
        end
    endgenerate

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        unique case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    state_d = FULL;
                    main_d  = in_data;
                end
            end
            FULL: begin
                if (in_fire && out_fire) begin
                    main_d = in_data;
                end else if (in_fire && SKID) begin
                    // Downstream stalled while a beat arrived: park it
                    // behind the main beat so ordering is preserved.
                    state_d = SKID_FULL;
                    skid_d  = in_data;
                end else if (out_fire) begin
                    state_d = EMPTY;
                    main_d  = NOP_VALUE;
                end
            end
            SKID_FULL: begin
                if (out_fire) begin
                    state_d = FULL;
                    main_d  = skid_q;
                    skid_d  = NOP_VALUE;
                end
            end
            default: begin
                state_d = EMPTY;
                main_d  = NOP_VALUE;
                skid_d  = NOP_VALUE;
            end
        endcase

        // Flush overrides the handshake result: an outgoing beat still
        // counts as delivered, an incoming one is dropped.
        if (flush) begin
            state_d = EMPTY;
            main_d  = NOP_VALUE;
            skid_d  = NOP_VALUE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            main_q  <= NOP_VALUE;
            skid_q  <= NOP_VALUE;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Self-checking bench for pipe_stage_hs. Two instances (SKID=1 and SKID=0)
// share the same stimulus; each has its own reference queue describing the
// beats it currently holds.
module tb_pipe_stage_hs;

    localparam logic [7:0] NOP = 8'h13;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic       out_ready = 1'b1;

    logic       rdy1, ov1, rdy0, ov0;
    logic [7:0] od1, od0;
    logic [1:0] occ1, occ0;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    bit          armed = 1'b0;

    logic [7:0] q1[$];
    logic [7:0] q0[$];

    always #5 clk = ~clk;

    pipe_stage_hs #(.WIDTH(8), .NOP_VALUE(NOP), .SKID(1'b1)) dut1 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy1), .in_data(in_data),
        .out_valid(ov1), .out_ready(out_ready), .out_data(od1),
        .occupancy(occ1)
    );

    pipe_stage_hs #(.WIDTH(8), .NOP_VALUE(NOP), .SKID(1'b0)) dut0 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy0), .in_data(in_data),
        .out_valid(ov0), .out_ready(out_ready), .out_data(od0),
        .occupancy(occ0)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares DUT against the held-beat queues at mid-cycle, then
    // advances the queues by the handshakes that the next edge will perform.
    always @(negedge clk) begin
        if (rst) begin
            q1.delete();
            q0.delete();
        end else begin
            if (armed) begin
                check("occ1", 32'(occ1), 32'(q1.size()));
                check("valid1", 32'(ov1), (q1.size() != 0) ? 32'd1 : 32'd0);
                check("ready1", 32'(rdy1), (q1.size() < 2) ? 32'd1 : 32'd0);
                if (q1.size() == 0) check("bubble1", 32'(od1), 32'(NOP));
                else                check("head1", 32'(od1), 32'(q1[0]));

                check("occ0", 32'(occ0), 32'(q0.size()));
                check("occ0_max", (occ0 <= 2'd1) ? 32'd1 : 32'd0, 32'd1);
                check("valid0", 32'(ov0), (q0.size() != 0) ? 32'd1 : 32'd0);
                check("ready0", 32'(rdy0), (q0.size() == 0 || out_ready) ? 32'd1 : 32'd0);
                if (q0.size() == 0) check("bubble0", 32'(od0), 32'(NOP));
                else                check("head0", 32'(od0), 32'(q0[0]));
            end
            if (ov1 && out_ready && q1.size() > 0) void'(q1.pop_front());
            if (in_valid && rdy1) q1.push_back(in_data);
            if (flush) q1.delete();
            if (ov0 && out_ready && q0.size() > 0) void'(q0.pop_front());
            if (in_valid && rdy0) q0.push_back(in_data);
            if (flush) q0.delete();
        end
    end

    initial begin
        // Reset with a valid beat offered: nothing may be captured.
        rst = 1'b1; in_valid = 1'b1; in_data = 8'hAA; out_ready = 1'b1;
        step();
        step();
        rst = 1'b0; in_valid = 1'b0;
        #0;
        check("rst_valid1", 32'(ov1), 32'd0);
        check("rst_data1", 32'(od1), 32'(NOP));
        check("rst_ready1", 32'(rdy1), 32'd1);
        check("rst_occ1", 32'(occ1), 32'd0);
        check("rst_valid0", 32'(ov0), 32'd0);
        check("rst_data0", 32'(od0), 32'(NOP));
        check("rst_occ0", 32'(occ0), 32'd0);
        armed = 1'b1;
        step();

        // Streaming 01..10 with out_ready high: one beat per cycle, 1-cycle latency.
        for (int i = 1; i <= 16; i++) begin
            in_valid = 1'b1; in_data = 8'(i);
            step();
            check("stream_data1", 32'(od1), 32'(i));
            check("stream_occ1", 32'(occ1), 32'd1);
            check("stream_data0", 32'(od0), 32'(i));
            check("stream_occ0", 32'(occ0), 32'd1);
        end
        in_valid = 1'b0;
        step();
        check("drain_valid1", 32'(ov1), 32'd0);

        // Stall into skid.
        in_valid = 1'b1; in_data = 8'h21;
        step();
        out_ready = 1'b0; in_data = 8'h22;
        step();
        check("skid_data", 32'(od1), 32'h21);
        check("skid_occ", 32'(occ1), 32'd2);
        check("skid_ready", 32'(rdy1), 32'd0);
        in_data = 8'h23;
        step();
        check("stall_hold", 32'(od1), 32'h21);
        check("stall_valid", 32'(ov1), 32'd1);
        out_ready = 1'b1;
        step();
        check("unstall_22", 32'(od1), 32'h22);
        step();
        check("unstall_23", 32'(od1), 32'h23);
        in_valid = 1'b0;
        step();
        check("unstall_empty", 32'(occ1), 32'd0);

        // Flush with skid full; 55 offered in the flush cycle.
        in_valid = 1'b1; in_data = 8'h31;
        step();
        out_ready = 1'b0; in_data = 8'h32;
        step();
        check("pre_flush_occ", 32'(occ1), 32'd2);
        flush = 1'b1; in_data = 8'h55;
        step();
        check("flush_valid", 32'(ov1), 32'd0);
        check("flush_data", 32'(od1), 32'(NOP));
        check("flush_occ", 32'(occ1), 32'd0);
        check("flush_ready", 32'(rdy1), 32'd1);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        step();

        // Flush while a beat leaves and another is accepted.
        in_valid = 1'b1; in_data = 8'h41;
        step();
        in_data = 8'h42; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        check("flush2_occ1", 32'(occ1), 32'd0);
        check("flush2_occ0", 32'(occ0), 32'd0);
        step();

        // SKID=0: in_ready follows out_ready combinationally while full.
        in_valid = 1'b1; in_data = 8'h61; out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        out_ready = 1'b0; #1;
        check("comb_ready_lo", 32'(rdy0), 32'd0);
        out_ready = 1'b1; #1;
        check("comb_ready_hi", 32'(rdy0), 32'd1);
        check("reg_ready_hi", 32'(rdy1), 32'd1);
        out_ready = 1'b0; #1;
        check("comb_ready_lo2", 32'(rdy0), 32'd0);
        step();
        out_ready = 1'b1;
        step();

        // Random back-pressure, sparse flushes and rare resets.
        for (int c = 0; c < 10000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 8'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 63) == 0);
            rst       = ($urandom_range(0, 999) == 0);
            step();
        end
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) step();
        check("final_q1", 32'(q1.size()), 32'd0);
        check("final_q0", 32'(q0.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
